// File: rtl/spi_regfile_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : spi_regfile_ctrl
// Description : Turns 8-bit SPI slave frames (command byte + data bytes) into
//               register-file read/write strobes with auto-incrementing address.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_regfile_ctrl #(
    parameter int          AW = 7,
    parameter logic [7:0]  ID = 8'hA5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          spi_start,
    input  logic          spi_done,
    input  logic          spi_busy,
    input  logic [7:0]    spi_dout,
    output logic [7:0]    spi_din,
    output logic [AW-1:0] reg_addr,
    output logic          reg_rd,
    input  logic [7:0]    reg_rdata,
    output logic          reg_wr,
    output logic [7:0]    reg_wdata,
    output logic          frame_err
);

    localparam logic [AW-1:0] c_addr_one = AW'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CMD    = 3'd1,
        S_WDATA  = 3'd2,
        S_RDUMMY = 3'd3,
        S_RDATA  = 3'd4
    } state_e;

    state_e        state_q, state_d;
    logic [7:0]    spi_din_q, spi_din_d;
    logic [AW-1:0] reg_addr_q, reg_addr_d;
    logic          reg_rd_q, reg_rd_d;
    logic          reg_wr_q, reg_wr_d;
    logic [7:0]    reg_wdata_q, reg_wdata_d;
    logic          frame_err_q, frame_err_d;
    logic [7:0]    rbuf_q, rbuf_d;
    logic          rd_pend_q, rd_pend_d;

    always_comb begin
        state_d     = state_q;
        spi_din_d   = spi_din_q;
        reg_addr_d  = reg_addr_q;
        reg_rd_d    = 1'b0;
        reg_wr_d    = 1'b0;
        reg_wdata_d = reg_wdata_q;
        frame_err_d = 1'b0;
        rbuf_d      = rbuf_q;
        rd_pend_d   = reg_rd_q;

        // Read data arrives one cycle after the strobe
        if (rd_pend_q) begin
            rbuf_d = reg_rdata;
        end

        // Write address advances only after the strobe has used it
        if (reg_wr_q) begin
            reg_addr_d = reg_addr_q + c_addr_one;
        end

        if (spi_start) begin
            state_d   = S_CMD;
            spi_din_d = ID;
        end else if (spi_done && (state_q != S_IDLE)) begin
            case (state_q)
                S_CMD: begin
                    reg_addr_d = spi_dout[AW-1:0];
                    if (spi_dout[7]) begin
                        spi_din_d = 8'h00;
                        reg_rd_d  = 1'b1;
                        state_d   = S_RDUMMY;
                    end else begin
                        spi_din_d = ID;
                        state_d   = S_WDATA;
                    end
                end
                S_WDATA: begin
                    reg_wr_d    = 1'b1;
                    reg_wdata_d = spi_dout;
                    spi_din_d   = ID;
                end
                S_RDUMMY, S_RDATA: begin
                    // Prefetched byte goes out; fetch the next one now
                    spi_din_d  = rbuf_q;
                    reg_addr_d = reg_addr_q + c_addr_one;
                    reg_rd_d   = 1'b1;
                    state_d    = S_RDATA;
                end
                default: state_d = S_IDLE;
            endcase
        end else if (!spi_busy && (state_q != S_IDLE)) begin
            state_d     = S_IDLE;
            frame_err_d = (state_q == S_CMD);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            spi_din_q   <= ID;
            reg_addr_q  <= '0;
            reg_rd_q    <= 1'b0;
            reg_wr_q    <= 1'b0;
            reg_wdata_q <= 8'h00;
            frame_err_q <= 1'b0;
            rbuf_q      <= 8'h00;
            rd_pend_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            spi_din_q   <= spi_din_d;
            reg_addr_q  <= reg_addr_d;
            reg_rd_q    <= reg_rd_d;
            reg_wr_q    <= reg_wr_d;
            reg_wdata_q <= reg_wdata_d;
            frame_err_q <= frame_err_d;
            rbuf_q      <= rbuf_d;
            rd_pend_q   <= rd_pend_d;
        end
    end

    assign spi_din   = spi_din_q;
    assign reg_addr  = reg_addr_q;
    assign reg_rd    = reg_rd_q;
    assign reg_wr    = reg_wr_q;
    assign reg_wdata = reg_wdata_q;
    assign frame_err = frame_err_q;

endmodule
`default_nettype wire
